fft_topn_peaks: RTL

FFT_TOPN_PEAKS -- requirements
Module: fft_topn_peaks

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_topn_sorter.sv | 61 ++++++
 rtl/fft_topn_peaks.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT top-N peak finder.
//   peak_entry_t : one ranked list slot (filled flag, magnitude, bin index).
//                  Fields are sized for the widest supported configuration
//                  (W <= MAG_MAX, NBits <= K_MAX); users zero-extend into them.
//   bit_rev      : reverses the low n bits of x (upper bits return zero).
//   drain_state_t: output drain FSM states.
package fft_pkg;

  localparam int MAG_MAX = 64;
  localparam int K_MAX   = 16;

  typedef struct packed {
    logic               filled;
    logic [MAG_MAX-1:0] mag;
    logic [K_MAX-1:0]   k;
  } peak_entry_t;

  localparam peak_entry_t EMPTY_ENTRY = '0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_state_t;

  function automatic logic [K_MAX-1:0] bit_rev(input logic [K_MAX-1:0] x,
                                               input int unsigned n);
    logic [K_MAX-1:0] r;
    r = '0;
    for (int b = 0; b < K_MAX; b++) begin
      if (b < int'(n)) r[b] = x[int'(n) - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_topn_sorter.sv
// Single-cycle sorted insert into an NPeaks-deep descending list.
//   clk, reset  : clock, synchronous active-low reset (list emptied)
//   insert_i    : ent_i is a candidate this cycle
//   clear_i     : empty the list after this cycle's insert (window end)
//   ent_i       : candidate entry (filled=1, magnitude, bin)
//   list_o      : post-insert view of the list (this cycle's candidate
//                 already placed), so a window-end copy includes the final
//                 sample without a dead cycle
module fft_topn_sorter
  import fft_pkg::*;
#(
  parameter int W      = 33,
  parameter int NBits  = 10,
  parameter int NPeaks = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        insert_i,
  input  logic        clear_i,
  input  peak_entry_t ent_i,
  output peak_entry_t list_o [NPeaks]
);

  peak_entry_t list_q [NPeaks];
  peak_entry_t list_d [NPeaks];
  peak_entry_t up     [NPeaks];
  peak_entry_t nent;
  logic [NPeaks-1:0] ge;

  // ge[j]: slot j keeps its place (filled and not strictly beaten). Since
  // the list is descending with filled slots first, ge is a run of ones
  // followed by zeros, and the candidate lands at the first zero.
  always_comb begin
    nent        = EMPTY_ENTRY;
    nent.filled = 1'b1;
    nent.mag    = MAG_MAX'(ent_i.mag[W-1:0]);
    nent.k      = K_MAX'(ent_i.k[NBits-1:0]);
    for (int j = 0; j < NPeaks; j++) begin
      ge[j] = list_q[j].filled && (list_q[j].mag[W-1:0] >= nent.mag[W-1:0]);
    end
    // up[j]: what slot j holds when it does not keep its own entry
    up[0] = nent;
    for (int j = 1; j < NPeaks; j++) begin
      up[j] = ge[j-1] ? nent : list_q[j-1];
    end
    for (int j = 0; j < NPeaks; j++) begin
      list_d[j] = (!insert_i || ge[j]) ? list_q[j] : up[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      for (int j = 0; j < NPeaks; j++) list_q[j] <= EMPTY_ENTRY;
    end else begin
      for (int j = 0; j < NPeaks; j++) list_q[j] <= list_d[j];
    end
  end

  assign list_o = list_d;

endmodule

// File: rtl/fft_topn_peaks.sv
// Per-window top-N peak search over a streamed FFT magnitude spectrum.
//   clk, reset          : clock, synchronous active-low reset
//   mag, mag_valid      : magnitude stream, no backpressure, gaps allowed
//   k_lo, k_hi          : inclusive bin search range, latched at window start
//   peak, peak_k        : ranked result entry (unfilled slots read 0/0)
//   peak_rank           : 0 = largest
//   peak_valid/ready    : result handshake, ranks presented 0..NPeaks-1
//   peak_last           : entry is the final rank
//   overrun             : pulse when a completed window result is dropped
module fft_topn_peaks
  import fft_pkg::*;
#(
  parameter int NSamples = 1024,
  parameter int W        = 33,
  parameter int NBits    = $clog2(NSamples),
  parameter int NPeaks   = 4,
  parameter int BitRev   = 1,
  localparam int RW      = $clog2(NPeaks) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     mag,
  input  logic             mag_valid,
  input  logic [NBits-1:0] k_lo,
  input  logic [NBits-1:0] k_hi,
  output logic [W-1:0]     peak,
  output logic [NBits-1:0] peak_k,
  output logic [RW-1:0]    peak_rank,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic             peak_last,
  output logic             overrun
);

  // ---------------- arrival counter and range latch ----------------
  logic [NBits-1:0] i_q, klo_q, khi_q;
  logic [NBits-1:0] klo_eff, khi_eff, k_cur;
  logic [K_MAX-1:0] k_rev;
  logic             first, last, cand, win_done;

  assign first    = (i_q == '0);
  assign last     = (i_q == NBits'(NSamples - 1));
  assign win_done = mag_valid && last;
  assign k_rev    = bit_rev(K_MAX'(i_q), NBits);
  assign k_cur    = (BitRev != 0) ? k_rev[NBits-1:0] : i_q;

  // The first sample of a window sees the live range; later ones the latch.
  assign klo_eff  = first ? k_lo : klo_q;
  assign khi_eff  = first ? k_hi : khi_q;

  // NSamples is a power of two, so k < NSamples/2 is just the top bit clear.
  assign cand     = mag_valid && !k_cur[NBits-1] &&
                    (k_cur >= klo_eff) && (k_cur <= khi_eff);

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q   <= '0;
      klo_q <= '0;
      khi_q <= '0;
    end else if (mag_valid) begin
      i_q <= last ? '0 : i_q + NBits'(1);
      if (first) begin
        klo_q <= k_lo;
        khi_q <= k_hi;
      end
    end
  end

  // ---------------- sorted search list ----------------
  peak_entry_t ent;
  peak_entry_t srch [NPeaks];

  always_comb begin
    ent        = EMPTY_ENTRY;
    ent.filled = 1'b1;
    ent.mag    = MAG_MAX'(mag);
    ent.k      = K_MAX'(k_cur);
  end

  fft_topn_sorter #(
    .W      (W),
    .NBits  (NBits),
    .NPeaks (NPeaks)
  ) u_sorter (
    .clk      (clk),
    .reset    (reset),
    .insert_i (cand),
    .clear_i  (win_done),
    .ent_i    (ent),
    .list_o   (srch)
  );

  // ---------------- output buffer and drain FSM ----------------
  // The buffer shifts toward slot 0 on each handshake, so the presented
  // entry is always buf_q[0]; after the final rank it has shifted out to
  // empty, which leaves peak/peak_k at zero while idle.
  drain_state_t   state_q;
  peak_entry_t    buf_q [NPeaks];
  logic [RW-1:0]  rank_q;
  logic           valid_q, last_q, ovr_q;
  logic           hs;

  assign hs = valid_q && peak_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      for (int j = 0; j < NPeaks; j++) buf_q[j] <= EMPTY_ENTRY;
      rank_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_done) begin
            for (int j = 0; j < NPeaks; j++) buf_q[j] <= srch[j];
            rank_q  <= '0;
            valid_q <= 1'b1;
            last_q  <= (NPeaks == 1);
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs && last_q) begin
            if (win_done) begin
              // Freed in the very cycle a new window lands: take it.
              for (int j = 0; j < NPeaks; j++) buf_q[j] <= srch[j];
              rank_q  <= '0;
              last_q  <= (NPeaks == 1);
            end else begin
              for (int j = 0; j < NPeaks; j++) buf_q[j] <= EMPTY_ENTRY;
              rank_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            if (hs) begin
              for (int j = 0; j < NPeaks - 1; j++) buf_q[j] <= buf_q[j+1];
              buf_q[NPeaks-1] <= EMPTY_ENTRY;
              rank_q <= rank_q + RW'(1);
              last_q <= (rank_q == RW'(NPeaks - 2));
            end
            ovr_q <= win_done;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign peak       = buf_q[0].mag[W-1:0];
  assign peak_k     = buf_q[0].k[NBits-1:0];
  assign peak_rank  = rank_q;
  assign peak_valid = valid_q;
  assign peak_last  = last_q;
  assign overrun    = ovr_q;

endmodule
